arith_cmd_issue: RTL and testbench

Upstream issue stage for the 16-bit arithmetic unit. It buffers operand/opcode commands from a valid/ready producer in a small FIFO and presents the FIFO head to the arithmetic unit's `data_1`/`data_2`/`op_sel` inputs. Because the arithmetic unit is combinational, the block captures its `data_out` in the same cycle into a result register, which it offers downstream through a valid/ready handshake. The block decouples bursty command sources from result consumers and adds full backpressure.

---
 rtl/arith_pkg.sv | 14 +
 rtl/arith_cmd_fifo.sv | 35 +++
 rtl/arith_cmd_issue.sv | 70 +++++++
 tb/tb_arith_cmd_issue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared opcodes, command struct and result-state type for the arithmetic issue stage.
package arith_pkg;
    localparam int ARITH_W = 16;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;
    typedef struct packed {
        logic [1:0]         op;
        logic [ARITH_W-1:0] d1;
        logic [ARITH_W-1:0] d2;
    } arith_cmd_t;
    typedef enum logic {RES_EMPTY, RES_FULL} res_state_t;
endpackage

// File: rtl/arith_cmd_fifo.sv
// arith_cmd_fifo: command FIFO with occupancy count and head-read.
module arith_cmd_fifo
    import arith_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  arith_cmd_t    din,
    output arith_cmd_t    head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    arith_cmd_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/arith_cmd_issue.sv
// arith_cmd_issue: buffers arithmetic commands, drives the combinational unit from the FIFO head
// and registers its result behind a valid/ready handshake.
module arith_cmd_issue
    import arith_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ARITH_W-1:0] cmd_data_1,
    input  logic [ARITH_W-1:0] cmd_data_2,
    input  logic [1:0]         cmd_op,
    output logic [ARITH_W-1:0] au_data_1,
    output logic [ARITH_W-1:0] au_data_2,
    output logic [1:0]         au_op_sel,
    input  logic [ARITH_W-1:0] au_data_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ARITH_W-1:0] res_data,
    output logic [1:0]         res_op,
    output logic [CW-1:0]      fifo_count,
    output logic [15:0]        done_count
);
    arith_cmd_t head, din;
    res_state_t state, state_nxt;
    logic push, pop, have;
    assign din       = '{op: cmd_op, d1: cmd_data_1, d2: cmd_data_2};
    assign cmd_ready = fifo_count < CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign have      = fifo_count != '0;
    assign pop       = have && (state == RES_EMPTY || res_ready);
    assign au_data_1 = have ? head.d1 : '0;
    assign au_data_2 = have ? head.d2 : '0;
    assign au_op_sel = have ? head.op : '0;
    assign res_valid = state == RES_FULL;

    arith_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (fifo_count)
    );

    // a pop always refills the result register, even while the old one is being delivered
    always_comb begin
        state_nxt = pop ? RES_FULL : (state == RES_FULL && res_ready) ? RES_EMPTY : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RES_EMPTY;
            res_data   <= '0;
            res_op     <= '0;
            done_count <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                res_data <= au_data_out;
                res_op   <= head.op;
            end
            if (res_valid && res_ready) done_count <= done_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_arith_cmd_issue.sv
// tb_arith_cmd_issue: directed checks of the issue stage against a behavioural arithmetic unit.
module tb_arith_cmd_issue;
    import arith_pkg::*;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, res_valid, res_ready;
    logic [15:0] cmd_data_1, cmd_data_2, au_data_1, au_data_2, au_data_out, res_data, done_count;
    logic [1:0]  cmd_op, au_op_sel, res_op;
    logic [2:0]  fifo_count;
    int total = 0;
    int bad   = 0;
    int acc, hs;

    always #5 clk = ~clk;

    arith_cmd_issue #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data_1  (cmd_data_1),
        .cmd_data_2  (cmd_data_2),
        .cmd_op      (cmd_op),
        .au_data_1   (au_data_1),
        .au_data_2   (au_data_2),
        .au_op_sel   (au_op_sel),
        .au_data_out (au_data_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_op      (res_op),
        .fifo_count  (fifo_count),
        .done_count  (done_count)
    );

    // combinational arithmetic unit
    always_comb begin
        au_data_out = 16'h0000;
        case (au_op_sel)
            OP_ADD:  au_data_out = au_data_1 + au_data_2;
            OP_SUB:  au_data_out = au_data_1 - au_data_2;
            OP_MUL:  au_data_out = au_data_1 * au_data_2;
            default: au_data_out = au_data_1 & au_data_2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        cmd_valid  = v;
        cmd_op     = op;
        cmd_data_1 = a;
        cmd_data_2 = b;
    endtask

    initial begin
        reset = 1'b0;
        res_ready = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_op", res_op, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", done_count, 0);
        chk("rst_au", {au_op_sel, au_data_1, au_data_2}, 0);
        reset = 1'b1;

        // single add, one cycle from acceptance to result
        drive(1'b1, OP_ADD, 16'h1234, 16'h0001);
        res_ready = 1'b1;
        @(negedge clk);
        chk("add_head_d1", au_data_1, 16'h1234);
        chk("add_head_d2", au_data_2, 16'h0001);
        chk("add_count", fifo_count, 1);
        chk("add_not_yet", res_valid, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", res_valid, 1);
        chk("add_data", res_data, 16'h1235);
        chk("add_op", res_op, OP_ADD);
        chk("add_drained_au", au_data_1, 0);

        // sub / mul / and back-to-back
        drive(1'b1, OP_SUB, 16'h0000, 16'h0001);
        @(negedge clk);
        chk("b2b_gap", res_valid, 0);
        chk("b2b_count", fifo_count, 1);
        drive(1'b1, OP_MUL, 16'h0100, 16'h0100);
        @(negedge clk);
        chk("sub_data", res_data, 16'hFFFF);
        chk("sub_op", res_op, OP_SUB);
        drive(1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        chk("mul_data", res_data, 16'h0000);
        chk("mul_op", res_op, OP_MUL);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("and_data", res_data, 16'h00F0);
        chk("and_op", res_op, OP_AND);
        @(negedge clk);
        chk("b2b_idle", res_valid, 0);
        chk("done_4", done_count, 4);

        // backpressure: six offered, five accepted
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'(i % 4), 16'h0010 + 16'(i), 16'h0003);
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 5);
        chk("bp_ready_low", cmd_ready, 0);
        chk("bp_count", fifo_count, 4);
        chk("bp_held", res_valid, 1);
        chk("bp_data0", res_data, 16'h0013);
        @(negedge clk);
        chk("stall_data", res_data, 16'h0013);
        chk("stall_op", res_op, OP_ADD);
        chk("stall_head", au_data_1, 16'h0011);
        chk("stall_count", fifo_count, 4);

        // drain with cmd_valid still high: pop without push, then push+pop
        res_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_count", fifo_count, 3);
        chk("full_pop_data1", res_data, 16'h000E);
        chk("full_pop_ready", cmd_ready, 1);
        @(negedge clk);
        chk("steady_count", fifo_count, 3);
        chk("drain_data2", res_data, 16'h0036);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("drain_data3", res_data, 16'h0003);
        chk("drain_count3", fifo_count, 2);
        @(negedge clk);
        chk("drain_data4", res_data, 16'h0017);
        chk("drain_count4", fifo_count, 1);
        @(negedge clk);
        chk("drain_data5", res_data, 16'h0012);
        chk("drain_op5", res_op, OP_SUB);
        chk("drain_count5", fifo_count, 0);
        @(negedge clk);
        chk("drain_idle", res_valid, 0);
        chk("done_10", done_count, 10);

        // reset mid-burst: 1 held, 3 queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_ADD, 16'(i + 1), 16'h0020);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 3);
        chk("pre_rst_held", res_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_done", done_count, 0);
        chk("mid_rst_au", {au_op_sel, au_data_1, au_data_2}, 0);
        @(negedge clk);
        reset = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", res_valid, 0);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_done", done_count, 0);

        // done_count wrap after 65536 deliveries
        drive(1'b1, OP_ADD, 16'h0001, 16'h0001);
        hs = 0;
        for (int c = 0; c < 70000 && hs < 65536; c++) begin
            if (res_valid && res_ready) hs++;
            @(posedge clk);
            #1;
            if (hs == 65535) chk("done_ffff", done_count, 16'hFFFF);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("wrap_handshakes", hs, 65536);
        chk("done_wrap", done_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
